// File: rtl/seq0110_pkg.sv
// seq0110_pkg: sync-sequence constants and framer state type shared by the 0110 link.
package seq0110_pkg;

    typedef enum logic [2:0] {IDLE, SYNC, DATA, PAR, GAP} tx_state_t;

    localparam logic [3:0] SYNC_PATTERN = 4'b0110;
    localparam int         SYNC_LEN     = 4;

    function automatic int max3(input int a, input int b, input int c);
        return a > b ? (a > c ? a : c) : (b > c ? b : c);
    endfunction

endpackage

// File: rtl/seq0110_framer_tx_if.sv
// seq0110_framer_tx_if: producer handshake plus serial line of the 0110 framer.
interface seq0110_framer_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_i;
    logic              valid_i;
    logic              ready_o;
    logic              out;
    logic              busy_o;
    logic              done_o;

    modport master (output data_i, valid_i, input ready_o, out, busy_o, done_o);
    modport slave  (input data_i, valid_i, output ready_o, out, busy_o, done_o);
endinterface

// File: rtl/seq0110_framer_tx_piso_shreg.sv
// piso_shreg: parallel-in serial-out register with load and shift enables, MSB out.
module piso_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);
    logic [W-1:0] sr;

    always_ff @(posedge clk or posedge rst)
        if (rst) sr <= '0;
        else if (load) sr <= din;
        else if (shift) sr <= sr << 1;

    assign msb = sr[W-1];
endmodule

// File: rtl/seq0110_framer_tx.sv
// seq0110_framer_tx: sends 0110 sync then the payload MSB first on a registered line.
// Define SEQ0110_TX_PARITY_EN to append an even-parity bit after the payload.
module seq0110_framer_tx
    import seq0110_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int GAP    = 1
) (
    input logic                clk,
    input logic                rst,
    seq0110_framer_tx_if.slave bus
);
    localparam int              CW        = $clog2(max3(DATA_W, GAP, SYNC_LEN) + 1);
    localparam logic [CW-1:0]   SYNC_LAST = CW'(SYNC_LEN - 1);
    localparam logic [CW-1:0]   DATA_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0]   GAP_LAST  = CW'(GAP == 0 ? 0 : GAP - 1);
    localparam tx_state_t       POST      = GAP > 0 ? seq0110_pkg::GAP : IDLE;
`ifdef SEQ0110_TX_PARITY_EN
    localparam tx_state_t       AFTER     = PAR;
`else
    localparam tx_state_t       AFTER     = POST;
`endif

    tx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          out_r, out_n, load, shift, msb;

    assign load  = state == IDLE && bus.valid_i;
    assign shift = state_n == DATA;

    piso_shreg #(.W(DATA_W)) u_shreg (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .shift(shift),
        .din  (bus.data_i),
        .msb  (msb)
    );

`ifdef SEQ0110_TX_PARITY_EN
    logic par;

    always_ff @(posedge clk or posedge rst)
        if (rst) par <= 1'b0;
        else if (load) par <= ^bus.data_i;
`endif

    // out_n is the value the line shows once the state moves to state_n
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        out_n   = 1'b1;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (bus.valid_i) begin
                    state_n = SYNC;
                    out_n   = SYNC_PATTERN[SYNC_LEN-1];
                end
            end
            SYNC: begin
                if (cnt == SYNC_LAST) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    out_n   = msb;
                end else out_n = SYNC_PATTERN[2'(SYNC_LEN - 2) - cnt[1:0]];
            end
            DATA: begin
                if (cnt == DATA_LAST) begin
                    state_n = AFTER;
                    cnt_n   = '0;
`ifdef SEQ0110_TX_PARITY_EN
                    out_n   = par;
`endif
                end else out_n = msb;
            end
`ifdef SEQ0110_TX_PARITY_EN
            PAR: begin
                state_n = POST;
                cnt_n   = '0;
            end
`endif
            seq0110_pkg::GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            out_r <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            out_r <= out_n;
        end

    assign bus.out     = out_r;
    assign bus.ready_o = state == IDLE;
    assign bus.busy_o  = state != IDLE;
`ifdef SEQ0110_TX_PARITY_EN
    assign bus.done_o  = state == PAR;
`else
    assign bus.done_o  = state == DATA && cnt == DATA_LAST;
`endif
endmodule

// File: tb/tb_seq0110_framer_tx.sv
// tb_seq0110_framer_tx: directed table and sequence checks of the 0110 framer (DATA_W=8, GAP=2).
module tb_seq0110_framer_tx;
    localparam int GAPC = 2;
`ifdef SEQ0110_TX_PARITY_EN
    localparam int FL = 13;
`else
    localparam int FL = 12;
`endif

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic [3:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[16];

    seq0110_framer_tx_if #(.DATA_W(8)) bus ();

    seq0110_framer_tx #(.DATA_W(8), .GAP(GAPC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] obs();
        return {bus.out, bus.done_o, bus.ready_o, bus.busy_o};
    endfunction

    // accept w on the next edge, then change data_i to nd mid-frame and check every frame bit
    task automatic tx_frame(input logic [7:0] w, input logic [7:0] nd, input logic nv);
        logic [FL-1:0] bits;
`ifdef SEQ0110_TX_PARITY_EN
        bits = {4'b0110, w, ^w};
`else
        bits = {4'b0110, w};
`endif
        step();
        bus.data_i  = nd;
        bus.valid_i = nv;
        for (int k = 1; k <= FL; k++) begin
            if (k > 1) step();
            check("frame_bit", {28'd0, obs()}, {28'd0, bits[FL-k], k == FL, 1'b0, 1'b1});
        end
    endtask

    task automatic gap_check();
        for (int g = 1; g <= GAPC + 1; g++) begin
            step();
            check("gap", {28'd0, obs()}, {28'd0, 1'b1, 1'b0, g == GAPC + 1, g != GAPC + 1});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        int seen_done;
        tbl[0]  = '{1'b1, 8'hA5, 4'b0001};
        tbl[1]  = '{1'b0, 8'h5A, 4'b1001};
        tbl[2]  = '{1'b0, 8'h5A, 4'b1001};
        tbl[3]  = '{1'b0, 8'h5A, 4'b0001};
        tbl[4]  = '{1'b0, 8'h5A, 4'b1001};
        tbl[5]  = '{1'b0, 8'h5A, 4'b0001};
        tbl[6]  = '{1'b0, 8'h5A, 4'b1001};
        tbl[7]  = '{1'b0, 8'h5A, 4'b0001};
        tbl[8]  = '{1'b0, 8'h5A, 4'b0001};
        tbl[9]  = '{1'b0, 8'h5A, 4'b1001};
        tbl[10] = '{1'b0, 8'h5A, 4'b0001};
`ifdef SEQ0110_TX_PARITY_EN
        tbl[11] = '{1'b0, 8'h5A, 4'b1001};
        tbl[12] = '{1'b0, 8'h5A, 4'b0101};
        tbl[13] = '{1'b0, 8'h5A, 4'b1001};
        tbl[14] = '{1'b0, 8'h5A, 4'b1001};
        tbl[15] = '{1'b0, 8'h5A, 4'b1010};
`else
        tbl[11] = '{1'b0, 8'h5A, 4'b1101};
        tbl[12] = '{1'b0, 8'h5A, 4'b1001};
        tbl[13] = '{1'b0, 8'h5A, 4'b1001};
        tbl[14] = '{1'b0, 8'h5A, 4'b1010};
        tbl[15] = '{1'b0, 8'h5A, 4'b1010};
`endif
        bus.valid_i = 1'b0;
        bus.data_i  = 8'h00;
        #1 rst = 1'b1;
        #1 check("reset_async", {28'd0, obs()}, {28'd0, 4'b1010});
        #20 rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (obs() !== 4'b1010) bad++;
        end
        check("idle_50", bad, 0);

        for (int i = 0; i < 16; i++) begin
            bus.valid_i = tbl[i].valid;
            bus.data_i  = tbl[i].data;
            step();
            check($sformatf("vec%0d", i), {28'd0, obs()}, {28'd0, tbl[i].exp});
        end

        bus.valid_i = 1'b1;
        bus.data_i  = 8'h00;
        tx_frame(8'h00, 8'hFF, 1'b1);
        gap_check();
        tx_frame(8'hFF, 8'h00, 1'b0);
        gap_check();

        bus.valid_i = 1'b1;
        bus.data_i  = 8'h96;
        step();
        bus.valid_i = 1'b0;
        repeat (6) step();
        check("third_payload_bit", {31'd0, bus.out}, {31'd0, 1'b0});
        #1 rst = 1'b1;
        #1 check("reset_midframe", {28'd0, obs()}, {28'd0, 4'b1010});
        #1 rst = 1'b0;
        step();
        check("idle_after_reset", {28'd0, obs()}, {28'd0, 4'b1010});
        seen_done = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) seen_done++;
        end
        check("no_done_after_reset", seen_done, 0);

        bus.valid_i = 1'b1;
        bus.data_i  = 8'h3C;
        tx_frame(8'h3C, 8'hC3, 1'b0);
        gap_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
